// File: rtl/bcd_stream_checker_if.sv
// rtl/bcd_stream_checker_if.sv - word stream and result bundle for the BCD stream checker
// master: drives in_valid_21, data_21, clr_21; observes in_ready_21 and the results
// slave : the checker; drives in_ready_21, out_valid_21, flag_21, digit_mask_21,
//         first_bad_21, err_count_21, sticky_err_21, locked_21
interface bcd_stream_checker_if #(
  parameter int DIGITS = 4,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 2
);
  logic                  in_valid_21;
  logic                  in_ready_21;
  logic [4*DIGITS-1:0]   data_21;
  logic                  clr_21;
  logic                  out_valid_21;
  logic                  flag_21;
  logic [DIGITS-1:0]     digit_mask_21;
  logic [IDX_W-1:0]      first_bad_21;
  logic [CNT_W-1:0]      err_count_21;
  logic                  sticky_err_21;
  logic                  locked_21;

  modport master (
    output in_valid_21, data_21, clr_21,
    input  in_ready_21, out_valid_21, flag_21, digit_mask_21, first_bad_21,
           err_count_21, sticky_err_21, locked_21
  );

  modport slave (
    input  in_valid_21, data_21, clr_21,
    output in_ready_21, out_valid_21, flag_21, digit_mask_21, first_bad_21,
           err_count_21, sticky_err_21, locked_21
  );
endinterface

// File: rtl/bcd_stream_checker.sv
// rtl/bcd_stream_checker.sv - packed-BCD word checker with error counting and lockout
// clk_21   : sole clock, rising edge
// rst_n_21 : asynchronous active-low reset
// bus      : bcd_stream_checker_if.slave (word input, clear, registered results, status)
module bcd_stream_checker #(
  parameter int DIGITS    = 4,
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 3,
  parameter int IDX_W     = 2
) (
  input  logic                  clk_21,
  input  logic                  rst_n_21,
  bcd_stream_checker_if.slave   bus
);

  // ERR_LIMIT never exceeds 255, so an 8-bit run counter always reaches it.
  localparam int                  CONSEC_W = 8;
  localparam logic [CONSEC_W-1:0] LIMIT    = CONSEC_W'(ERR_LIMIT);
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = {CONSEC_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CONSEC_W-1:0]   consec_q, consec_d;
  logic [CNT_W-1:0]      err_count_q, err_count_d;
  logic                  sticky_q, sticky_d;
  logic                  out_valid_q, out_valid_d;
  logic                  flag_q, flag_d;
  logic [DIGITS-1:0]     mask_q, mask_d;
  logic [IDX_W-1:0]      first_bad_q, first_bad_d;

  logic                  in_ready_c;
  logic                  accept_c;
  logic [DIGITS-1:0]     mask_c;
  logic [IDX_W-1:0]      first_bad_c;
  logic                  bad_c;
  logic [CONSEC_W-1:0]   consec_inc_c;

  // Per-digit classification: 10..15 is not a decimal digit.
  always_comb begin
    mask_c = '0;
    for (int k = 0; k < DIGITS; k++) begin
      mask_c[k] = (bus.data_21[4*k +: 4] > 4'd9);
    end
  end

  // Lowest bad digit wins, so scan downward and let the last hit stick.
  always_comb begin
    first_bad_c = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (mask_c[k]) begin
        first_bad_c = IDX_W'(k);
      end
    end
  end

  assign bad_c        = |mask_c;
  assign in_ready_c   = (state_q == ST_RUN);
  // A clear in the same cycle discards the word even though in_ready_21 may be high.
  assign accept_c     = bus.in_valid_21 && in_ready_c && !bus.clr_21;
  assign consec_inc_c = (consec_q == CONSEC_MAX) ? consec_q : consec_q + 1'b1;

  // State machine: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (bus.clr_21) begin
          state_d = ST_RUN;
        end else if (accept_c && bad_c && (consec_inc_c >= LIMIT)) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (bus.clr_21) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Counters, sticky flag and result registers.
  always_comb begin
    consec_d    = consec_q;
    err_count_d = err_count_q;
    sticky_d    = sticky_q;
    out_valid_d = accept_c;
    flag_d      = flag_q;
    mask_d      = mask_q;
    first_bad_d = first_bad_q;

    if (bus.clr_21) begin
      consec_d    = '0;
      err_count_d = '0;
      sticky_d    = 1'b0;
    end else if (accept_c) begin
      flag_d      = bad_c;
      mask_d      = mask_c;
      first_bad_d = first_bad_c;
      if (bad_c) begin
        consec_d = consec_inc_c;
        sticky_d = 1'b1;
        if (err_count_q != CNT_MAX) begin
          err_count_d = err_count_q + 1'b1;
        end
      end else begin
        consec_d = '0;
      end
    end
  end

  always_ff @(posedge clk_21 or negedge rst_n_21) begin
    if (!rst_n_21) begin
      state_q     <= ST_RUN;
      consec_q    <= '0;
      err_count_q <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      flag_q      <= 1'b0;
      mask_q      <= '0;
      first_bad_q <= '0;
    end else begin
      state_q     <= state_d;
      consec_q    <= consec_d;
      err_count_q <= err_count_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      flag_q      <= flag_d;
      mask_q      <= mask_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign bus.in_ready_21   = in_ready_c;
  assign bus.out_valid_21  = out_valid_q;
  assign bus.flag_21       = flag_q;
  assign bus.digit_mask_21 = mask_q;
  assign bus.first_bad_21  = first_bad_q;
  assign bus.err_count_21  = err_count_q;
  assign bus.sticky_err_21 = sticky_q;
  assign bus.locked_21     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_bcd_stream_checker.sv
// tb/tb_bcd_stream_checker.sv - directed self-checking bench for bcd_stream_checker
module tb_bcd_stream_checker;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bcd_stream_checker_if #(.DIGITS(4), .CNT_W(8), .IDX_W(2)) bus ();
  bcd_stream_checker_if #(.DIGITS(4), .CNT_W(2), .IDX_W(2)) bus2 ();

  bcd_stream_checker #(.DIGITS(4), .CNT_W(8), .ERR_LIMIT(3), .IDX_W(2)) dut (
    .clk_21   (clk),
    .rst_n_21 (rst_n),
    .bus      (bus)
  );

  bcd_stream_checker #(.DIGITS(4), .CNT_W(2), .ERR_LIMIT(8), .IDX_W(2)) dut2 (
    .clk_21   (clk),
    .rst_n_21 (rst_n),
    .bus      (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid_21 = 1'b0; bus.data_21 = '0; bus.clr_21 = 1'b0;
    bus2.in_valid_21 = 1'b0; bus2.data_21 = '0; bus2.clr_21 = 1'b0;
    tick();
    tick();
    vectors++; if (bus.out_valid_21 !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %0b expected 0", bus.out_valid_21); end
    vectors++; if (bus.flag_21 !== 1'b0) begin miscompares++; $display("FAIL rst_flag: got %0b expected 0", bus.flag_21); end
    vectors++; if (bus.digit_mask_21 !== 4'b0000) begin miscompares++; $display("FAIL rst_mask: got %b expected 0000", bus.digit_mask_21); end
    vectors++; if (bus.first_bad_21 !== 2'd0) begin miscompares++; $display("FAIL rst_first_bad: got %0d expected 0", bus.first_bad_21); end
    vectors++; if (bus.err_count_21 !== 8'd0) begin miscompares++; $display("FAIL rst_err_count: got %0d expected 0", bus.err_count_21); end
    vectors++; if (bus.sticky_err_21 !== 1'b0) begin miscompares++; $display("FAIL rst_sticky: got %0b expected 0", bus.sticky_err_21); end
    vectors++; if (bus.locked_21 !== 1'b0) begin miscompares++; $display("FAIL rst_locked: got %0b expected 0", bus.locked_21); end
    vectors++; if (bus.in_ready_21 !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %0b expected 1", bus.in_ready_21); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_word();
    bus.data_21 = 16'h1234; bus.in_valid_21 = 1'b1;
    tick();
    bus.in_valid_21 = 1'b0;
    vectors++; if (bus.out_valid_21 !== 1'b1) begin miscompares++; $display("FAIL good_out_valid: got %0b expected 1", bus.out_valid_21); end
    vectors++; if (bus.flag_21 !== 1'b0) begin miscompares++; $display("FAIL good_flag: got %0b expected 0", bus.flag_21); end
    vectors++; if (bus.digit_mask_21 !== 4'b0000) begin miscompares++; $display("FAIL good_mask: got %b expected 0000", bus.digit_mask_21); end
    vectors++; if (bus.first_bad_21 !== 2'd0) begin miscompares++; $display("FAIL good_first_bad: got %0d expected 0", bus.first_bad_21); end
    vectors++; if (bus.err_count_21 !== 8'd0) begin miscompares++; $display("FAIL good_err_count: got %0d expected 0", bus.err_count_21); end
    tick();
    vectors++; if (bus.out_valid_21 !== 1'b0) begin miscompares++; $display("FAIL good_pulse_width: got %0b expected 0", bus.out_valid_21); end
  endtask

  task automatic test_bad_word();
    bus.data_21 = 16'hA9F3; bus.in_valid_21 = 1'b1;
    tick();
    bus.in_valid_21 = 1'b0;
    vectors++; if (bus.out_valid_21 !== 1'b1) begin miscompares++; $display("FAIL bad_out_valid: got %0b expected 1", bus.out_valid_21); end
    vectors++; if (bus.flag_21 !== 1'b1) begin miscompares++; $display("FAIL bad_flag: got %0b expected 1", bus.flag_21); end
    vectors++; if (bus.digit_mask_21 !== 4'b1010) begin miscompares++; $display("FAIL bad_mask: got %b expected 1010", bus.digit_mask_21); end
    vectors++; if (bus.first_bad_21 !== 2'd1) begin miscompares++; $display("FAIL bad_first_bad: got %0d expected 1", bus.first_bad_21); end
    vectors++; if (bus.err_count_21 !== 8'd1) begin miscompares++; $display("FAIL bad_err_count: got %0d expected 1", bus.err_count_21); end
    vectors++; if (bus.sticky_err_21 !== 1'b1) begin miscompares++; $display("FAIL bad_sticky: got %0b expected 1", bus.sticky_err_21); end
    tick();
    vectors++; if (bus.out_valid_21 !== 1'b0) begin miscompares++; $display("FAIL bad_pulse_width: got %0b expected 0", bus.out_valid_21); end
    vectors++; if (bus.digit_mask_21 !== 4'b1010) begin miscompares++; $display("FAIL bad_mask_hold: got %b expected 1010", bus.digit_mask_21); end
  endtask

  task automatic test_clear();
    bus.clr_21 = 1'b1;
    tick();
    bus.clr_21 = 1'b0;
    vectors++; if (bus.err_count_21 !== 8'd0) begin miscompares++; $display("FAIL clr_err_count: got %0d expected 0", bus.err_count_21); end
    vectors++; if (bus.sticky_err_21 !== 1'b0) begin miscompares++; $display("FAIL clr_sticky: got %0b expected 0", bus.sticky_err_21); end
    vectors++; if (bus.digit_mask_21 !== 4'b1010) begin miscompares++; $display("FAIL clr_mask_kept: got %b expected 1010", bus.digit_mask_21); end
    vectors++; if (bus.first_bad_21 !== 2'd1) begin miscompares++; $display("FAIL clr_first_bad_kept: got %0d expected 1", bus.first_bad_21); end
  endtask

  task automatic test_lock();
    logic [15:0] words [6];
    logic [7:0]  exp_cnt [6];
    words[0] = 16'h000A; words[1] = 16'hC000; words[2] = 16'h0000;
    words[3] = 16'h0B00; words[4] = 16'hFFFF; words[5] = 16'h00E0;
    exp_cnt[0] = 8'd1; exp_cnt[1] = 8'd2; exp_cnt[2] = 8'd2;
    exp_cnt[3] = 8'd3; exp_cnt[4] = 8'd4; exp_cnt[5] = 8'd5;
    for (int i = 0; i < 6; i++) begin
      bus.data_21 = words[i]; bus.in_valid_21 = 1'b1;
      tick();
      vectors++; if (bus.err_count_21 !== exp_cnt[i]) begin miscompares++; $display("FAIL lock_err_count[%0d]: got %0d expected %0d", i, bus.err_count_21, exp_cnt[i]); end
      if (i < 5) begin
        vectors++; if (bus.locked_21 !== 1'b0) begin miscompares++; $display("FAIL lock_early[%0d]: got %0b expected 0", i, bus.locked_21); end
      end
    end
    vectors++; if (bus.locked_21 !== 1'b1) begin miscompares++; $display("FAIL lock_locked: got %0b expected 1", bus.locked_21); end
    vectors++; if (bus.in_ready_21 !== 1'b0) begin miscompares++; $display("FAIL lock_in_ready: got %0b expected 0", bus.in_ready_21); end
    vectors++; if (bus.first_bad_21 !== 2'd1) begin miscompares++; $display("FAIL lock_first_bad: got %0d expected 1", bus.first_bad_21); end
    bus.data_21 = 16'h00AA;
    tick();
    bus.in_valid_21 = 1'b0;
    vectors++; if (bus.out_valid_21 !== 1'b0) begin miscompares++; $display("FAIL lock_ignored_pulse: got %0b expected 0", bus.out_valid_21); end
    vectors++; if (bus.err_count_21 !== 8'd5) begin miscompares++; $display("FAIL lock_ignored_count: got %0d expected 5", bus.err_count_21); end
  endtask

  task automatic test_clr_in_locked();
    bus.data_21 = 16'hAAAA; bus.in_valid_21 = 1'b1; bus.clr_21 = 1'b1;
    tick();
    bus.clr_21 = 1'b0; bus.in_valid_21 = 1'b0;
    vectors++; if (bus.out_valid_21 !== 1'b0) begin miscompares++; $display("FAIL clrlk_dropped: got %0b expected 0", bus.out_valid_21); end
    vectors++; if (bus.locked_21 !== 1'b0) begin miscompares++; $display("FAIL clrlk_locked: got %0b expected 0", bus.locked_21); end
    vectors++; if (bus.err_count_21 !== 8'd0) begin miscompares++; $display("FAIL clrlk_err_count: got %0d expected 0", bus.err_count_21); end
    vectors++; if (bus.sticky_err_21 !== 1'b0) begin miscompares++; $display("FAIL clrlk_sticky: got %0b expected 0", bus.sticky_err_21); end
    vectors++; if (bus.in_ready_21 !== 1'b1) begin miscompares++; $display("FAIL clrlk_in_ready: got %0b expected 1", bus.in_ready_21); end
    bus.data_21 = 16'h9F99; bus.in_valid_21 = 1'b1;
    tick();
    bus.in_valid_21 = 1'b0;
    vectors++; if (bus.out_valid_21 !== 1'b1) begin miscompares++; $display("FAIL clrlk_reaccept: got %0b expected 1", bus.out_valid_21); end
    vectors++; if (bus.first_bad_21 !== 2'd2) begin miscompares++; $display("FAIL clrlk_first_bad: got %0d expected 2", bus.first_bad_21); end
    vectors++; if (bus.err_count_21 !== 8'd1) begin miscompares++; $display("FAIL clrlk_err_after: got %0d expected 1", bus.err_count_21); end
  endtask

  task automatic test_reset_mid();
    bus.data_21 = 16'hB000; bus.in_valid_21 = 1'b1;
    tick();
    vectors++; if (bus.out_valid_21 !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_valid: got %0b expected 1", bus.out_valid_21); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid_21 !== 1'b0) begin miscompares++; $display("FAIL rmid_out_valid: got %0b expected 0", bus.out_valid_21); end
    vectors++; if (bus.flag_21 !== 1'b0) begin miscompares++; $display("FAIL rmid_flag: got %0b expected 0", bus.flag_21); end
    vectors++; if (bus.digit_mask_21 !== 4'b0000) begin miscompares++; $display("FAIL rmid_mask: got %b expected 0000", bus.digit_mask_21); end
    vectors++; if (bus.first_bad_21 !== 2'd0) begin miscompares++; $display("FAIL rmid_first_bad: got %0d expected 0", bus.first_bad_21); end
    vectors++; if (bus.err_count_21 !== 8'd0) begin miscompares++; $display("FAIL rmid_err_count: got %0d expected 0", bus.err_count_21); end
    vectors++; if (bus.sticky_err_21 !== 1'b0) begin miscompares++; $display("FAIL rmid_sticky: got %0b expected 0", bus.sticky_err_21); end
    vectors++; if (bus.in_ready_21 !== 1'b1) begin miscompares++; $display("FAIL rmid_in_ready: got %0b expected 1", bus.in_ready_21); end
    bus.in_valid_21 = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (bus.out_valid_21 !== 1'b0) begin miscompares++; $display("FAIL rmid_after_release[%0d]: got %0b expected 0", i, bus.out_valid_21); end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    bus2.data_21 = 16'hD000; bus2.in_valid_21 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (bus2.err_count_21 !== exp_cnt[i]) begin miscompares++; $display("FAIL sat_err_count[%0d]: got %0d expected %0d", i, bus2.err_count_21, exp_cnt[i]); end
    end
    bus2.in_valid_21 = 1'b0;
    vectors++; if (bus2.locked_21 !== 1'b0) begin miscompares++; $display("FAIL sat_locked: got %0b expected 0", bus2.locked_21); end
    vectors++; if (bus2.first_bad_21 !== 2'd3) begin miscompares++; $display("FAIL sat_first_bad: got %0d expected 3", bus2.first_bad_21); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_good_word();
    test_bad_word();
    test_clear();
    test_lock();
    test_clr_in_locked();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
